// File: rtl/alu_pkg.sv
// Shared opcode, FSM-state encodings and opcode-class helpers for the
// sequential ALU and its multiply/divide core.
package alu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_SLL   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_AND   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_XOR   = 4'b0111;
  localparam logic [3:0] OP_MULT  = 4'b1000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1010;
  localparam logic [3:0] OP_DIVU  = 4'b1011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  function automatic logic is_muldiv(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_md(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative one-bit-per-cycle shift-add multiplier / restoring divider working
// on operand magnitudes; the signed fix-up is folded into the final-cycle outputs.
module seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH);

  logic             run_q;
  logic             div_q;
  logic             neg_lo_q;
  logic             neg_hi_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] hi_n, lo_n;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    a_neg = is_signed_md(op_i) && a_i[WIDTH-1];
    b_neg = is_signed_md(op_i) && b_i[WIDTH-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
  end

  // Multiply keeps the product in {hi,lo} with the multiplier draining out of lo;
  // divide keeps the partial remainder in hi and shifts quotient bits into lo.
  always_comb begin
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted[WIDTH-1:0] - m_q;
    if (div_q) begin
      if (shifted >= {1'b0, m_q}) begin
        hi_n = diff;
        lo_n = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_n = shifted[WIDTH-1:0];
        lo_n = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_n = add_sum[WIDTH:1];
      lo_n = {add_sum[0], lo_q[WIDTH-1:1]};
    end
    prod = neg_lo_q ? -{hi_n, lo_n} : {hi_n, lo_n};
  end

  assign ready_o = run_q && (cnt_q == CW'(WIDTH - 1));
  assign hi_o    = div_q ? (neg_hi_q ? -hi_n : hi_n) : prod[2*WIDTH-1:WIDTH];
  assign lo_o    = div_q ? (neg_lo_q ? -lo_n : lo_n) : prod[WIDTH-1:0];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      cnt_q    <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else if (go_i) begin
      run_q    <= 1'b1;
      div_q    <= is_div(op_i);
      neg_lo_q <= a_neg ^ b_neg;
      neg_hi_q <= a_neg;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= is_div(op_i) ? a_mag : b_mag;
      m_q      <= is_div(op_i) ? b_mag : a_mag;
    end else if (run_q) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + CW'(1);
      if (ready_o) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle registered ALU: single-cycle basic ops plus iterative mul/div
// behind a start/busy/done handshake for a stalling control FSM.
module seq_alu
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             start,
  input  logic [3:0]       ALUOp,
  input  logic [WIDTH-1:0] regA,
  input  logic [WIDTH-1:0] regB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             zero,
  output logic             sign,
  output logic             div_by_zero
);

  logic [1:0]       state_q, state_d;
  logic             done_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH-1:0] basic_res;
  logic             md_go, md_ready;
  logic [WIDTH-1:0] md_hi, md_lo;

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (CLK),
    .rst_n  (Reset),
    .go_i   (md_go),
    .op_i   (ALUOp),
    .a_i    (regA),
    .b_i    (regB),
    .ready_o(md_ready),
    .hi_o   (md_hi),
    .lo_o   (md_lo)
  );

  always_comb begin
    case (ALUOp)
      OP_ADD:  basic_res = regA + regB;
      OP_SUB:  basic_res = regA - regB;
      OP_SLL:  basic_res = regB << regA[SHW-1:0];
      OP_OR:   basic_res = regA | regB;
      OP_AND:  basic_res = regA & regB;
      OP_SLTU: basic_res = (regA < regB) ? WIDTH'(1) : '0;
      OP_SLT:  basic_res = ($signed(regA) < $signed(regB)) ? WIDTH'(1) : '0;
      OP_XOR:  basic_res = regA ^ regB;
      default: basic_res = '0;
    endcase
  end

  // NOTE: every always_comb output gets a hold-value default first, so no
  // path through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
    md_go    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dbz_d   = 1'b0;
          state_d = ST_FIN;
          if (!is_muldiv(ALUOp)) begin
            result_d = basic_res;
          end else if (is_div(ALUOp) && (regB == '0)) begin
            hi_d     = regA;
            lo_d     = '1;
            result_d = '1;
            dbz_d    = 1'b1;
          end else begin
            md_go   = 1'b1;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (md_ready) begin
          hi_d     = md_hi;
          lo_d     = md_lo;
          result_d = md_lo;
          state_d  = ST_FIN;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= (state_q == ST_FIN);
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q == ST_CALC);
  assign done        = done_q;
  assign result      = result_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;
  assign zero        = (result_q == '0);
  assign sign        = result_q[WIDTH-1];

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: an independent reference model pushes expected
// results at issue time; they are popped and compared when done pulses.
module tb_seq_alu;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ALUOp = 4'h0;
  logic [31:0] regA = '0, regB = '0;
  logic        busy, done, zero, sign, div_by_zero;
  logic [31:0] result, hi, lo;

  seq_alu #(.WIDTH(32)) dut (
    .CLK(CLK), .Reset(Reset), .start(start), .ALUOp(ALUOp), .regA(regA), .regB(regB),
    .busy(busy), .done(done), .result(result), .hi(hi), .lo(lo),
    .zero(zero), .sign(sign), .div_by_zero(div_by_zero)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] res, hi, lo;
    logic        dbz;
    int          lat, busy_n;
  } exp_t;

  typedef struct {
    logic [31:0] res, hi, lo;
    logic        zero, sign, dbz;
  } obs_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b;
  } vec_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_res = '0, m_hi = '0, m_lo = '0;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      ps;
    logic [63:0] pu;
    int          q, r;
    e.res = '0; e.hi = m_hi; e.lo = m_lo; e.dbz = 1'b0; e.lat = 1; e.busy_n = 0;
    case (op)
      4'h0: e.res = a + b;
      4'h1: e.res = a - b;
      4'h2: e.res = b << a[4:0];
      4'h3: e.res = a | b;
      4'h4: e.res = a & b;
      4'h5: e.res = (a < b) ? 32'd1 : 32'd0;
      4'h6: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'h7: e.res = a ^ b;
      4'h8: begin
        ps = longint'($signed(a)) * longint'($signed(b));
        {e.hi, e.lo} = ps;
      end
      4'h9: begin
        pu = {32'd0, a} * {32'd0, b};
        {e.hi, e.lo} = pu;
      end
      4'hA, 4'hB: begin
        if (b == 32'd0) begin
          e.hi = a; e.lo = '1; e.dbz = 1'b1;
        end else if (op == 4'hA && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.hi = '0; e.lo = a;
        end else if (op == 4'hA) begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          e.lo = q; e.hi = r;
        end else begin
          e.lo = a / b; e.hi = a % b;
        end
      end
      default: e.res = '0;
    endcase
    if (op[3:2] == 2'b10) begin
      e.res = e.lo;
      if (!e.dbz) begin e.lat = 33; e.busy_n = 32; end
    end
    return e;
  endfunction

  // Issue one op in the next cycle and wait (bounded) for done; no checking here.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output obs_t o, output int lat, output int busy_n, output bit timeout);
    @(negedge CLK);
    start = 1'b1; ALUOp = op; regA = a; regB = b;
    @(posedge CLK); #1;
    start = 1'b0;
    busy_n = int'(busy); lat = 0; timeout = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge CLK); #1;
      if (done) begin lat = i; timeout = 1'b0; break; end
      busy_n += int'(busy);
    end
    o.res = result; o.hi = hi; o.lo = lo; o.zero = zero; o.sign = sign; o.dbz = div_by_zero;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_vec++; if (busy !== 1'b0)         begin n_err++; $display("FAIL reset busy got %b want 0", busy); end
    n_vec++; if (done !== 1'b0)         begin n_err++; $display("FAIL reset done got %b want 0", done); end
    n_vec++; if (result !== 32'd0)      begin n_err++; $display("FAIL reset result got %h want 0", result); end
    n_vec++; if ({hi, lo} !== 64'd0)    begin n_err++; $display("FAIL reset hi/lo got %h_%h want 0", hi, lo); end
    n_vec++; if (div_by_zero !== 1'b0)  begin n_err++; $display("FAIL reset dbz got %b want 0", div_by_zero); end
    n_vec++; if ({zero, sign} !== 2'b10) begin n_err++; $display("FAIL reset zero/sign got %b want 10", {zero, sign}); end
    @(negedge CLK);
    Reset = 1'b1;
  endtask

  task automatic test_ops();
    vec_t vecs[$];
    obs_t o;
    exp_t e;
    int   lat, bn;
    bit   to;
    vecs = '{
      '{4'h0, 32'h7FFF_FFFF, 32'h0000_0001}, '{4'h1, 32'h0000_0000, 32'h0000_0001},
      '{4'h6, 32'hFFFF_FFFF, 32'h0000_0001}, '{4'h5, 32'hFFFF_FFFF, 32'h0000_0001},
      '{4'h2, 32'h0000_0024, 32'h0000_0001}, '{4'h3, 32'hF0F0_0000, 32'h0000_0F0F},
      '{4'h4, 32'hFF00_FF00, 32'h0FF0_0FF0}, '{4'h7, 32'hFFFF_0000, 32'h0F0F_0F0F},
      '{4'h0, 32'hFFFF_FFFF, 32'h0000_0001}, '{4'h8, 32'hFFFF_FFFE, 32'h0000_0003},
      '{4'hC, 32'h1234_5678, 32'h9ABC_DEF0}, '{4'h9, 32'hFFFF_FFFE, 32'h0000_0003},
      '{4'hA, 32'hFFFF_FFF9, 32'h0000_0002}, '{4'hB, 32'h8000_0000, 32'h0000_0000},
      '{4'hF, 32'h0000_0001, 32'h0000_0001}, '{4'hA, 32'h8000_0000, 32'hFFFF_FFFF},
      '{4'hA, 32'h0000_0007, 32'hFFFF_FFFE}, '{4'hB, 32'hFFFF_FFFF, 32'h0000_0010},
      '{4'h8, 32'h8000_0000, 32'h8000_0000}, '{4'hA, 32'h0000_0005, 32'h0000_0000}
    };
    for (int k = 0; k < 16; k++)
      vecs.push_back('{4'($urandom_range(0, 15)), $urandom(), $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 9)) : $urandom()});
    foreach (vecs[i]) begin
      e = model(vecs[i].op, vecs[i].a, vecs[i].b);
      exp_q.push_back(e);
      m_res = e.res; m_hi = e.hi; m_lo = e.lo;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, o, lat, bn, to);
      e = exp_q.pop_front();
      n_vec++; if (to)             begin n_err++; $display("FAIL op%0d(%h) done timeout", i, vecs[i].op); end
      n_vec++; if (lat != e.lat)   begin n_err++; $display("FAIL op%0d(%h) latency got %0d want %0d", i, vecs[i].op, lat, e.lat); end
      n_vec++; if (bn != e.busy_n) begin n_err++; $display("FAIL op%0d(%h) busy cycles got %0d want %0d", i, vecs[i].op, bn, e.busy_n); end
      n_vec++; if (o.res !== e.res) begin n_err++; $display("FAIL op%0d(%h) result got %h want %h", i, vecs[i].op, o.res, e.res); end
      n_vec++; if (o.hi !== e.hi)  begin n_err++; $display("FAIL op%0d(%h) hi got %h want %h", i, vecs[i].op, o.hi, e.hi); end
      n_vec++; if (o.lo !== e.lo)  begin n_err++; $display("FAIL op%0d(%h) lo got %h want %h", i, vecs[i].op, o.lo, e.lo); end
      n_vec++; if (o.dbz !== e.dbz) begin n_err++; $display("FAIL op%0d(%h) dbz got %b want %b", i, vecs[i].op, o.dbz, e.dbz); end
      n_vec++; if ({o.zero, o.sign} !== {e.res == 32'd0, e.res[31]})
        begin n_err++; $display("FAIL op%0d(%h) zero/sign got %b%b want %b%b", i, vecs[i].op, o.zero, o.sign, e.res == 32'd0, e.res[31]); end
    end
  endtask

  task automatic test_abort();
    obs_t o;
    exp_t e;
    int   lat, bn, done_seen;
    bit   to;
    done_seen = 0;
    @(negedge CLK);
    start = 1'b1; ALUOp = 4'hA; regA = 32'd100; regB = 32'd7;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge CLK);
      start = (c == 5);
      if (c == 5) begin ALUOp = 4'h0; regA = 32'd1; regB = 32'd1; end
      if (c == 10) Reset = 1'b0;
      #1;
      if (c < 10 && done) done_seen++;
      if (c == 9) begin
        n_vec++; if (busy !== 1'b1)    begin n_err++; $display("FAIL abort busy-before-reset got %b want 1", busy); end
        n_vec++; if (result !== m_res) begin n_err++; $display("FAIL abort ignored-start result got %h want %h", result, m_res); end
      end
    end
    start = 1'b0;
    n_vec++; if (done_seen != 0) begin n_err++; $display("FAIL abort early done got %0d want 0", done_seen); end
    n_vec++; if ({busy, done, div_by_zero} !== 3'b000)
      begin n_err++; $display("FAIL abort reset flags got %b want 000", {busy, done, div_by_zero}); end
    n_vec++; if ({result, hi, lo} !== 96'd0)
      begin n_err++; $display("FAIL abort reset data got %h_%h_%h want 0", result, hi, lo); end
    @(negedge CLK);
    Reset = 1'b1;
    m_res = '0; m_hi = '0; m_lo = '0;
    e = model(4'h0, 32'd2, 32'd3);
    exp_q.push_back(e);
    run_op(4'h0, 32'd2, 32'd3, o, lat, bn, to);
    e = exp_q.pop_front();
    n_vec++; if (to || lat != e.lat) begin n_err++; $display("FAIL abort add latency got %0d want %0d", lat, e.lat); end
    n_vec++; if ({o.res, o.hi, o.lo} !== {e.res, e.hi, e.lo})
      begin n_err++; $display("FAIL abort add got %h/%h/%h want %h/%h/%h", o.res, o.hi, o.lo, e.res, e.hi, e.lo); end
    m_res = e.res;
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    int   lat, bn;
    bit   to;
    e = model(4'h9, 32'h0001_0000, 32'h0001_0000);
    exp_q.push_back(e);
    m_res = e.res; m_hi = e.hi; m_lo = e.lo;
    run_op(4'h9, 32'h0001_0000, 32'h0001_0000, o, lat, bn, to);
    e = exp_q.pop_front();
    n_vec++; if (to || lat != e.lat) begin n_err++; $display("FAIL b2b multu latency got %0d want %0d", lat, e.lat); end
    n_vec++; if ({o.hi, o.lo} !== {e.hi, e.lo})
      begin n_err++; $display("FAIL b2b multu hi/lo got %h/%h want %h/%h", o.hi, o.lo, e.hi, e.lo); end
    e = model(4'h0, 32'd1, 32'd1);
    exp_q.push_back(e);
    m_res = e.res;
    run_op(4'h0, 32'd1, 32'd1, o, lat, bn, to);
    e = exp_q.pop_front();
    n_vec++; if (to || lat != e.lat) begin n_err++; $display("FAIL b2b add latency got %0d want %0d", lat, e.lat); end
    n_vec++; if ({o.res, o.hi, o.lo} !== {e.res, e.hi, e.lo})
      begin n_err++; $display("FAIL b2b add got %h/%h/%h want %h/%h/%h", o.res, o.hi, o.lo, e.res, e.hi, e.lo); end
    @(posedge CLK); #1;
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL b2b done width got %b want 0", done); end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_abort();
    test_back_to_back();
    if (exp_q.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard leftover got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
